// File: rtl/pwr_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwr_seq_pkg : state encoding, default timing values, rail helper. Rev 1.0 |
// +--------------------------------------------------------------------------+
package pwr_seq_pkg;

    localparam int DEF_N_RAIL     = 3;
    localparam int DEF_STAGE_DLY  = 50_000_000;
    localparam int DEF_REL_DLY    = 1_000;
    localparam int DEF_PG_TIMEOUT = 5_000_000;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_DLY   = 3'd1,
        S_PG    = 3'd2,
        S_REL   = 3'd3,
        S_ON    = 3'd4,
        S_DOWN  = 3'd5,
        S_OFF   = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Drops the most significant set bit; used for reverse-order shutdown.
    function automatic logic [7:0] clear_highest(input logic [7:0] v);
        logic [7:0] r;
        logic       found;
        r     = v;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i] && !found) begin
                r[i]  = 1'b0;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_timer : loadable down-counter, saturates at zero, tc when zero. Rev 1.0|
// +--------------------------------------------------------------------------+
module seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule
`default_nettype wire

// File: rtl/power_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | power_seq_ctrl : ordered rail power-up/down sequencer with reset release.  |
// | Define POWER_SEQ_PGOOD_EN to enable pgood checking. Rev 1.0                |
// +--------------------------------------------------------------------------+
module power_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int N_RAIL     = DEF_N_RAIL,
    parameter int STAGE_DLY  = DEF_STAGE_DLY,
    parameter int REL_DLY    = DEF_REL_DLY,
    parameter int PG_TIMEOUT = DEF_PG_TIMEOUT
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [N_RAIL-1:0] pgood,
    input  logic              pwr_on,
    input  logic              pwr_off,
    input  logic              fault_clr,
    output logic [N_RAIL-1:0] rail_en,
    output logic              rst_out,
    output logic              done,
    output logic              fault
);

    localparam int KW   = (N_RAIL > 1) ? $clog2(N_RAIL) : 1;
    localparam int MAXD = max3(STAGE_DLY, REL_DLY, PG_TIMEOUT);
    localparam int CW   = $clog2(MAXD + 1);

    localparam logic [CW-1:0] LD_STAGE = CW'(STAGE_DLY - 1);
    localparam logic [CW-1:0] LD_REL   = CW'(REL_DLY - 1);
    localparam logic [CW-1:0] LD_PGTO  = CW'(PG_TIMEOUT - 1);
    localparam logic [KW-1:0] LAST     = KW'(N_RAIL - 1);

    state_t            state;
    logic [KW-1:0]     k;
    logic              tc;
    logic              tmr_load;
    logic [CW-1:0]     tmr_val;
    logic              pg_ok;
    logic              pg_to;
    logic              on_bad;
    logic [N_RAIL-1:0] rail_dn;

`ifdef POWER_SEQ_PGOOD_EN
    assign pg_ok  = pgood[k];
    assign pg_to  = tc;
    assign on_bad = ~&pgood;
`else
    logic unused_pgood;
    assign unused_pgood = ^pgood;
    assign pg_ok  = 1'b1;
    assign pg_to  = 1'b0;
    assign on_bad = 1'b0;
`endif

    assign rail_dn = N_RAIL'(clear_highest(8'(rail_en)));

    // The timer is reloaded on the same edge the state changes, so each
    // new state starts with a fresh count from its first cycle.
    always_comb begin
        tmr_load = 1'b1;
        tmr_val  = LD_STAGE;
        case (state)
            S_DLY: begin
                tmr_load = pwr_off | tc;
                if (!pwr_off) tmr_val = LD_PGTO;
            end
            S_PG: begin
                tmr_load = pwr_off | pg_ok | pg_to;
                if (!pwr_off && pg_ok && (k == LAST)) tmr_val = LD_REL;
            end
            S_REL:   tmr_load = pwr_off | tc;
            S_DOWN:  tmr_load = tc;
            default: tmr_load = 1'b1;
        endcase
    end

    seq_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (1'b1),
        .load_val (tmr_val),
        .tc       (tc)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state   <= S_RST;
            k       <= '0;
            rail_en <= '0;
            rst_out <= 1'b1;
            done    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            case (state)
                S_RST: begin
                    state <= S_DLY;
                    k     <= '0;
                end
                S_DLY: begin
                    if (pwr_off) begin
                        state <= (rail_en == '0) ? S_OFF : S_DOWN;
                    end else if (tc) begin
                        rail_en[k] <= 1'b1;
                        state      <= S_PG;
                    end
                end
                S_PG: begin
                    if (pwr_off) begin
                        state <= S_DOWN;
                    end else if (pg_ok) begin
                        if (k == LAST) begin
                            state <= S_REL;
                        end else begin
                            k     <= k + KW'(1);
                            state <= S_DLY;
                        end
                    end else if (pg_to) begin
                        rail_en <= '0;
                        rst_out <= 1'b1;
                        done    <= 1'b0;
                        fault   <= 1'b1;
                        state   <= S_FAULT;
                    end
                end
                S_REL: begin
                    if (pwr_off) begin
                        state <= S_DOWN;
                    end else if (tc) begin
                        rst_out <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_ON;
                    end
                end
                S_ON: begin
                    // A lost rail outranks an orderly shutdown request.
                    if (on_bad) begin
                        rail_en <= '0;
                        rst_out <= 1'b1;
                        done    <= 1'b0;
                        fault   <= 1'b1;
                        state   <= S_FAULT;
                    end else if (pwr_off) begin
                        rst_out <= 1'b1;
                        done    <= 1'b0;
                        state   <= S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (tc) begin
                        rail_en <= rail_dn;
                        if (rail_dn == '0) state <= S_OFF;
                    end
                end
                S_OFF: begin
                    if (pwr_on) begin
                        k     <= '0;
                        state <= S_DLY;
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        fault <= 1'b0;
                        state <= S_OFF;
                    end
                end
                default: state <= S_RST;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_power_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_power_seq_ctrl : timeline-model bench for power_seq_ctrl. Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_power_seq_ctrl;

    localparam int N     = 3;
    localparam int STAGE = 4;
    localparam int REL   = 8;
    localparam int PGTO  = 10;
    localparam int INF   = 1_000_000_000;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic [N-1:0] pgood;
    logic         pwr_on, pwr_off, fault_clr;
    logic [N-1:0] rail_en;
    logic         rst_out, done, fault;

    power_seq_ctrl #(
        .N_RAIL     (N),
        .STAGE_DLY  (STAGE),
        .REL_DLY    (REL),
        .PG_TIMEOUT (PGTO)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .pgood     (pgood),
        .pwr_on    (pwr_on),
        .pwr_off   (pwr_off),
        .fault_clr (fault_clr),
        .rail_en   (rail_en),
        .rst_out   (rst_out),
        .done      (done),
        .fault     (fault)
    );

    always #10 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Expected behaviour as a timeline: edge numbers where each output changes.
    int rise [N];
    int fall [N];
    int on_at, on_end, flt_at, flt_end;
    int dly [N];
    int hi  [N];
    logic [N-1:0] hold, force_low;
    logic  noise;
    string phase;
    int    s, tgt;

    function automatic logic [N+2:0] expv(input int t);
        logic [N-1:0] r;
        logic d, f;
        for (int i = 0; i < N; i++) r[i] = (rise[i] <= t) && (t < fall[i]);
        d = (on_at <= t) && (t < on_end);
        f = (flt_at <= t) && (t < flt_end);
        return {r, ~d, d, f};
    endfunction

    task automatic check(input logic [N+2:0] obs, input logic [N+2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed {rail_en,rst_out,done,fault}=%b expected=%b",
                   phase, cyc, obs, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) begin
            rise[i] = INF;
            fall[i] = INF;
        end
        on_at = INF; on_end = INF; flt_at = INF; flt_end = INF;
    endtask

    // Everything still pending at edge x is cancelled; anything active stops at x.
    task automatic cut(input int x);
        for (int i = 0; i < N; i++) begin
            if (rise[i] < x) begin
                if (fall[i] > x) fall[i] = x;
            end else begin
                rise[i] = INF;
            end
        end
        if (on_at < x) begin
            if (on_end > x) on_end = x;
        end else begin
            on_at = INF;
        end
        if (flt_at < x) begin
            if (flt_end > x) flt_end = x;
        end else begin
            flt_at = INF;
        end
    endtask

    task automatic fault_at(input int x);
        cut(x);
        flt_at  = x;
        flt_end = INF;
    endtask

    task automatic plan_up(input int st);
        int t;
        clear_plan();
        t = st;
        for (int i = 0; i < N; i++) begin
            t += STAGE;
            rise[i] = t;
`ifdef POWER_SEQ_PGOOD_EN
            if (hold[i]) begin
                fault_at(t + PGTO);
                return;
            end
            t += dly[i];
`else
            t += 1;
`endif
        end
        on_at = t + REL;
    endtask

    task automatic plan_down(input int p);
        int n;
        n = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rise[i] < p) begin
                if (fall[i] > p) begin
                    n++;
                    fall[i] = p + n * STAGE;
                end
            end else begin
                rise[i] = INF;
            end
        end
        if (on_at < p) on_end = p;
        else           on_at  = INF;
    endtask

    task automatic pg_apply();
`ifdef POWER_SEQ_PGOOD_EN
        for (int i = 0; i < N; i++)
            pgood[i] = (hi[i] >= dly[i]) && !hold[i] && !force_low[i];
`else
        pgood = noise ? N'($urandom) : '0;
`endif
    endtask

    task automatic step();
        @(negedge clk_in);
        check({rail_en, rst_out, done, fault}, expv(cyc));
        for (int i = 0; i < N; i++) hi[i] = rail_en[i] ? hi[i] + 1 : 0;
        pg_apply();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic new_dly();
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 3);
    endtask

    task automatic on_now();
        new_dly();
        s = cyc + 1;
        plan_up(s);
        pwr_on = 1'b1;
        step();
        pwr_on = 1'b0;
    endtask

    task automatic off_now();
        plan_down(cyc + 1);
        pwr_off = 1'b1;
        step();
        pwr_off = 1'b0;
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog cyc=%0d observed=no summary expected=summary", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pwr_on = 1'b0; pwr_off = 1'b0; fault_clr = 1'b0;
        pgood = '0; hold = '0; force_low = '0; noise = 1'b0;
        for (int i = 0; i < N; i++) begin
            hi[i]  = 0;
            dly[i] = 1;
        end
        clear_plan();
        phase = "reset";
        run(3);

        phase = "auto_powerup";
        new_dly();
        rst_n = 1'b1;
        plan_up(cyc + 1);
        run_to(on_at + 3);
        noise = 1'b1;

        phase = "on_ignores_pwr_on";
        pwr_on = 1'b1; step(); pwr_on = 1'b0;
        run($urandom_range(0, 3));

        phase = "powerdown";
        off_now();
        run(N * STAGE + 2);

        phase = "off_idle";
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        run(2);

        for (int a = 0; a < 4; a++) begin
            phase = (a == 0) ? "abort_none" : "abort_rand";
            on_now();
            tgt = (a == 0) ? s + 1 : s + $urandom_range(1, on_at - s);
            run_to(tgt - 1);
            off_now();
            run(N * STAGE + 2);
        end

        phase = "ramp";
        on_now();
        run_to(on_at + 2);

`ifdef POWER_SEQ_PGOOD_EN
        phase = "pg_drop_with_off";
        force_low[N-1] = 1'b1;
        pg_apply();
        fault_at(cyc + 1);
        pwr_off = 1'b1; step(); pwr_off = 1'b0;
        run(4);

        phase = "clr_with_on";
        flt_end = cyc + 1;
        fault_clr = 1'b1; pwr_on = 1'b1; step(); fault_clr = 1'b0; pwr_on = 1'b0;
        run(4);
        force_low = '0;
        pg_apply();

        phase = "pg_timeout_r1";
        hold[1] = 1'b1;
        on_now();
        run_to(flt_at + 3);
        flt_end = cyc + 1;
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        hold = '0;
        run(2);

        phase = "restart";
        on_now();
        run_to(on_at + 2);

        phase = "pg_drop_rand";
        force_low[$urandom_range(0, N - 1)] = 1'b1;
        pg_apply();
        fault_at(cyc + 1);
        step();
        run(3);
        flt_end = cyc + 1;
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        force_low = '0;
        pg_apply();
        run(2);
        on_now();
        run_to(on_at + 2);
`endif

        phase = "reset_mid_pg1";
        off_now();
        run(N * STAGE + 2);
        on_now();
        run_to(rise[1]);
        rst_n = 1'b0;
        cut(cyc + 1);
        step();
        rst_n = 1'b1;
        phase = "reset_restart";
        new_dly();
        plan_up(cyc + 1);
        run_to(on_at + 2);

        phase = "reset_rand";
        off_now();
        run(N * STAGE + 2);
        on_now();
        tgt = s + $urandom_range(1, on_at - s + 3);
        run_to(tgt - 1);
        rst_n = 1'b0;
        cut(cyc + 1);
        step();
        rst_n = 1'b1;
        new_dly();
        plan_up(cyc + 1);
        run_to(on_at + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
